coloringfb_output_stage: RTL and testbench



---
 rtl/coloringfb_output_stage.sv | 124 ++++++++++++
 tb/tb_coloringfb_output_stage.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coloringfb_output_stage.sv
// Output stage: buffers coloring-kernel pixel words and re-emits them as framed stream.
// Optional OUTPUT_FRAME_HEADER_EN prepends a header word to each frame.
module coloringfb_output_stage #(
  parameter int DATA_WIDTH      = 32,
  parameter int FIFO_DEPTH_BITS = 4,
  parameter int FRAME_WORDS     = 16384,
  parameter int FRAME_CNT_BITS  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     Input_1_V_TDATA,
  input  logic                      Input_1_V_TVALID,
  output logic                      Input_1_V_TREADY,
  output logic [DATA_WIDTH-1:0]     Output_1_V_TDATA,
  output logic                      Output_1_V_TVALID,
  input  logic                      Output_1_V_TREADY,
  output logic                      Output_1_V_TLAST,
  output logic                      frame_done,
  output logic [FRAME_CNT_BITS-1:0] frame_count
);

  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int WCW   = $clog2(FRAME_WORDS);

  typedef enum logic {HDR, DATA} state_t;

  logic [DATA_WIDTH-1:0]      mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wptr;
  logic [FIFO_DEPTH_BITS-1:0] rptr;
  logic [FIFO_DEPTH_BITS:0]   occ;
  logic [WCW-1:0]             word_cnt;
  logic                       done_q;
  state_t                     state;
  state_t                     state_nxt;

  logic push;
  logic pop;
  logic last_word;
  logic data_hs;

  // Ready looks only at registered occupancy, so a full FIFO
  // refuses input even while a pop is happening.
  assign Input_1_V_TREADY = (occ != (FIFO_DEPTH_BITS+1)'(DEPTH));
  assign push      = Input_1_V_TVALID & Input_1_V_TREADY;
  assign last_word = (word_cnt == WCW'(FRAME_WORDS - 1));
  assign pop       = data_hs;
  assign frame_done  = done_q;

  always_comb begin
    state_nxt         = state;
    Output_1_V_TVALID = 1'b0;
    Output_1_V_TDATA  = mem[rptr];
    Output_1_V_TLAST  = 1'b0;
    data_hs           = 1'b0;
    unique case (state)
      HDR: begin
`ifdef OUTPUT_FRAME_HEADER_EN
        Output_1_V_TVALID = 1'b1;
        Output_1_V_TDATA  =
          DATA_WIDTH'({8'hFB, 8'h00, 16'(frame_count)});
        if (Output_1_V_TREADY)
          state_nxt = DATA;
`else
        state_nxt = DATA;
`endif
      end
      DATA: begin
        Output_1_V_TVALID = (occ != '0);
        Output_1_V_TLAST  = Output_1_V_TVALID & last_word;
        data_hs = Output_1_V_TVALID & Output_1_V_TREADY;
        if (data_hs && last_word) begin
`ifdef OUTPUT_FRAME_HEADER_EN
          state_nxt = HDR;
`else
          state_nxt = DATA;
`endif
        end
      end
      default: state_nxt = DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= Input_1_V_TDATA;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr        <= '0;
      rptr        <= '0;
      occ         <= '0;
      word_cnt    <= '0;
      frame_count <= '0;
      done_q      <= 1'b0;
`ifdef OUTPUT_FRAME_HEADER_EN
      state       <= HDR;
`else
      state       <= DATA;
`endif
    end else begin
      state  <= state_nxt;
      done_q <= data_hs & last_word;
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (data_hs) begin
        if (last_word) begin
          word_cnt    <= '0;
          frame_count <= frame_count + 1'b1;
        end else begin
          word_cnt <= word_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_coloringfb_output_stage.sv
// Directed bench for coloringfb_output_stage (FRAME_WORDS=8, 2-bit frame counter).
`timescale 1ns/1ps
module tb_coloringfb_output_stage;

`ifdef OUTPUT_FRAME_HEADER_EN
  localparam bit HDR_ON = 1'b1;
`else
  localparam bit HDR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        frame_done;
  logic [1:0]  frame_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] q_data[$];
  bit          q_last[$];
  int          q_cyc[$];
  int          in_cyc[$];
  int          done_cyc[$];
  logic [1:0]  done_fc[$];

  coloringfb_output_stage #(
    .DATA_WIDTH(32),
    .FIFO_DEPTH_BITS(4),
    .FRAME_WORDS(8),
    .FRAME_CNT_BITS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Input_1_V_TDATA(in_data),
    .Input_1_V_TVALID(in_valid),
    .Input_1_V_TREADY(in_ready),
    .Output_1_V_TDATA(out_data),
    .Output_1_V_TVALID(out_valid),
    .Output_1_V_TREADY(out_ready),
    .Output_1_V_TLAST(out_last),
    .frame_done(frame_done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) in_cyc.push_back(cyc);
      if (out_valid && out_ready) begin
        q_data.push_back(out_data);
        q_last.push_back(out_last);
        q_cyc.push_back(cyc);
      end
      if (frame_done) begin
        done_cyc.push_back(cyc);
        done_fc.push_back(frame_count);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic clear_q();
    q_data.delete(); q_last.delete(); q_cyc.delete();
    in_cyc.delete(); done_cyc.delete(); done_fc.delete();
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_q();
  endtask

  task automatic send(input logic [31:0] w);
    int n;
    @(posedge clk); #1;
    in_data = w; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk); n++;
    end
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL send_timeout word=%0h", w);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int k;
    k = 0;
    while (q_data.size() < n && k < 500) begin
      @(negedge clk); k++;
    end
    if (k >= 500) begin
      total++; bad++;
      $display("FAIL wait_out got=%0d need=%0d", q_data.size(), n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic exp_v;
    apply_reset();
    @(negedge clk);
    exp_v = HDR_ON;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++;
    if (out_valid !== exp_v) begin bad++; $display("FAIL rst_out_valid got=%b exp=%b", out_valid, exp_v); end
    total++;
    if (out_last !== 1'b0) begin bad++; $display("FAIL rst_last got=%b exp=0", out_last); end
    total++;
    if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", frame_done); end
    total++;
    if (frame_count !== 2'd0) begin bad++; $display("FAIL rst_fc got=%0d exp=0", frame_count); end
    if (HDR_ON) begin
      total++;
      if (out_data !== 32'hFB000000) begin bad++; $display("FAIL rst_hdr got=%h exp=fb000000", out_data); end
    end
  endtask

  task automatic test_basic();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(i);
    idle();
    wait_out(8);
    total++;
    if (q_data.size() !== 8) begin bad++; $display("FAIL basic_count got=%0d exp=8", q_data.size()); end
    for (int i = 0; i < 8 && i < q_data.size(); i++) begin
      total++;
      if (q_data[i] !== 32'(i + 1)) begin bad++; $display("FAIL basic_data[%0d] got=%0h exp=%0h", i, q_data[i], i + 1); end
      total++;
      if (q_last[i] !== (i == 7)) begin bad++; $display("FAIL basic_last[%0d] got=%b exp=%b", i, q_last[i], i == 7); end
      total++;
      if (q_cyc[i] !== in_cyc[i] + 1) begin bad++; $display("FAIL basic_latency[%0d] got=%0d exp=%0d", i, q_cyc[i], in_cyc[i] + 1); end
    end
    total++;
    if (done_cyc.size() !== 1) begin bad++; $display("FAIL basic_done_cnt got=%0d exp=1", done_cyc.size()); end
    else if (q_cyc.size() == 8) begin
      total++;
      if (done_cyc[0] !== q_cyc[7] + 1) begin bad++; $display("FAIL basic_done_cyc got=%0d exp=%0d", done_cyc[0], q_cyc[7] + 1); end
    end
    total++;
    if (frame_count !== 2'd1) begin bad++; $display("FAIL basic_fc got=%0d exp=1", frame_count); end
  endtask

  task automatic test_backpressure();
    bit rd[21];
    apply_reset();
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      in_data = i; in_valid = 1'b1;
      @(negedge clk);
      rd[i] = in_ready;
    end
    idle();
    for (int i = 1; i <= 20; i++) begin
      total++;
      if (rd[i] !== (i <= 16)) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=%b", i, rd[i], i <= 16); end
    end
    total++;
    if (in_cyc.size() !== 16) begin bad++; $display("FAIL bp_accepted got=%0d exp=16", in_cyc.size()); end
    total++;
    if (q_data.size() !== 0) begin bad++; $display("FAIL bp_no_out got=%0d exp=0", q_data.size()); end
    out_ready = 1'b1;
    for (int i = 17; i <= 20; i++) send(i);
    idle();
    wait_out(20);
    total++;
    if (q_data.size() !== 20) begin bad++; $display("FAIL bp_count got=%0d exp=20", q_data.size()); end
    for (int i = 0; i < 20 && i < q_data.size(); i++) begin
      total++;
      if (q_data[i] !== 32'(i + 1)) begin bad++; $display("FAIL bp_data[%0d] got=%0h exp=%0h", i, q_data[i], i + 1); end
    end
  endtask

  task automatic test_random();
    apply_reset();
    fork
      begin
        for (int i = 1; i <= 24; i++) begin
          do begin
            @(posedge clk); #1;
            in_valid = 1'($urandom_range(0, 1));
            in_data = i;
            @(negedge clk);
          end while (!(in_valid && in_ready));
        end
        idle();
      end
      begin
        for (int k = 0; k < 600 && q_data.size() < 24; k++) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    wait_out(24);
    total++;
    if (q_data.size() !== 24) begin bad++; $display("FAIL rnd_count got=%0d exp=24", q_data.size()); end
    for (int i = 0; i < 24 && i < q_data.size(); i++) begin
      total++;
      if (q_data[i] !== 32'(i + 1)) begin bad++; $display("FAIL rnd_data[%0d] got=%0h exp=%0h", i, q_data[i], i + 1); end
      total++;
      if (q_last[i] !== (i % 8 == 7)) begin bad++; $display("FAIL rnd_last[%0d] got=%b exp=%b", i, q_last[i], i % 8 == 7); end
    end
    total++;
    if (done_cyc.size() !== 3) begin bad++; $display("FAIL rnd_done_cnt got=%0d exp=3", done_cyc.size()); end
    total++;
    if (frame_count !== 2'd3) begin bad++; $display("FAIL rnd_fc got=%0d exp=3", frame_count); end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_fc [4];
    exp_fc[0] = 2'd1; exp_fc[1] = 2'd2;
    exp_fc[2] = 2'd3; exp_fc[3] = 2'd0;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 32; i++) send(i);
    idle();
    wait_out(32);
    total++;
    if (done_fc.size() !== 4) begin bad++; $display("FAIL wrap_done_cnt got=%0d exp=4", done_fc.size()); end
    for (int i = 0; i < 4 && i < done_fc.size(); i++) begin
      total++;
      if (done_fc[i] !== exp_fc[i]) begin bad++; $display("FAIL wrap_fc[%0d] got=%0d exp=%0d", i, done_fc[i], exp_fc[i]); end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) send(i);
    idle();
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b0;
    for (int i = 6; i <= 8; i++) send(i);
    idle();
    total++;
    if (q_data.size() !== 5) begin bad++; $display("FAIL mid_pre_out got=%0d exp=5", q_data.size()); end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    clear_q();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
    total++;
    if (frame_count !== 2'd0) begin bad++; $display("FAIL mid_fc got=%0d exp=0", frame_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(32'h100 + i);
    idle();
    wait_out(8);
    total++;
    if (q_data.size() !== 8) begin bad++; $display("FAIL mid_count got=%0d exp=8", q_data.size()); end
    for (int i = 0; i < 8 && i < q_data.size(); i++) begin
      total++;
      if (q_data[i] !== 32'h100 + i) begin bad++; $display("FAIL mid_data[%0d] got=%0h exp=%0h", i, q_data[i], 32'h100 + i); end
      total++;
      if (q_last[i] !== (i == 7)) begin bad++; $display("FAIL mid_last[%0d] got=%b exp=%b", i, q_last[i], i == 7); end
    end
    total++;
    if (frame_count !== 2'd1) begin bad++; $display("FAIL mid_fc_after got=%0d exp=1", frame_count); end
  endtask

  task automatic test_header();
    logic [31:0] exp[$];
    bit          expl[$];
    apply_reset();
    exp.push_back(32'hFB000000); expl.push_back(1'b0);
    for (int i = 1; i <= 8; i++) begin exp.push_back(i); expl.push_back(i == 8); end
    exp.push_back(32'hFB000001); expl.push_back(1'b0);
    for (int i = 9; i <= 16; i++) begin exp.push_back(i); expl.push_back(i == 16); end
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) send(i);
    idle();
    wait_out(18);
    total++;
    if (q_data.size() < 18) begin bad++; $display("FAIL hdr_count got=%0d exp>=18", q_data.size()); end
    for (int i = 0; i < 18 && i < q_data.size(); i++) begin
      total++;
      if (q_data[i] !== exp[i]) begin bad++; $display("FAIL hdr_data[%0d] got=%0h exp=%0h", i, q_data[i], exp[i]); end
      total++;
      if (q_last[i] !== expl[i]) begin bad++; $display("FAIL hdr_last[%0d] got=%b exp=%b", i, q_last[i], expl[i]); end
    end
    total++;
    if (frame_count !== 2'd2) begin bad++; $display("FAIL hdr_fc got=%0d exp=2", frame_count); end
  endtask

  initial begin
    test_reset();
`ifdef OUTPUT_FRAME_HEADER_EN
    test_header();
`else
    test_basic();
    test_backpressure();
    test_random();
    test_wrap();
    test_reset_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
